// File: rtl/avg_window_controller.sv
// Sequencer for a downstream moving averager. It flushes the averager, waits for the
// window to fill, then paces decimated output-valid pulses while running.
module avg_window_controller #(
    parameter int G_MAX_LENGTH_LOG = 10,
    parameter int G_FLUSH_CYCLES   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_control0,
    input  logic [15:0] i_control1,
    input  logic        i_sample_strobe,
    output logic        o_avg_clear,
    output logic        o_avg_enable,
    output logic [3:0]  o_avg_length_log,
    output logic        o_output_valid,
    output logic        o_busy,
    output logic [1:0]  o_state
);
    // state | meaning
    // IDLE  | disabled, averager outputs held low
    // FLUSH | averager clear held for G_FLUSH_CYCLES cycles
    // FILL  | accepting samples until the window holds 2^len samples
    // RUN   | steady state, decimated output-valid pulses
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FLUSH = 2'b01;
    localparam logic [1:0] S_FILL  = 2'b10;
    localparam logic [1:0] S_RUN   = 2'b11;

    localparam int              LP_FW         = (G_FLUSH_CYCLES > 1) ? $clog2(G_FLUSH_CYCLES) : 1;
    localparam logic [LP_FW-1:0] LP_FLUSH_LOAD = LP_FW'(G_FLUSH_CYCLES - 1);
    localparam logic [3:0]      LP_MAX_LOG    = 4'(G_MAX_LENGTH_LOG);
    localparam int              LP_CW         = G_MAX_LENGTH_LOG + 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [LP_FW-1:0] r_flush_cnt;
    logic [LP_FW-1:0] w_flush_cnt_next;
    logic [LP_CW-1:0] r_fill_cnt;
    logic [LP_CW-1:0] w_fill_cnt_next;
    logic [15:0]      r_dec_cnt;
    logic [15:0]      w_dec_cnt_next;
    logic [3:0]       r_len;
    logic [3:0]       w_len_next;
    logic             r_avg_clear;
    logic             w_avg_clear_next;
    logic             r_output_valid;
    logic             w_output_valid_next;

    logic             w_en;
    logic [3:0]       w_lreq;
    logic             w_len_chg;
    logic [LP_CW-1:0] w_fill_target;
    logic             w_fill_done;
    logic [15:0]      w_deff_m1;
    logic             w_dec_wrap;
    logic             w_unused_ctrl;

    assign w_en          = i_control0[15];
    assign w_lreq        = (i_control0[3:0] > LP_MAX_LOG) ? LP_MAX_LOG : i_control0[3:0];
    assign w_len_chg     = (w_lreq != r_len);
    assign w_fill_target = LP_CW'(1) << r_len;
    assign w_fill_done   = i_sample_strobe && ((r_fill_cnt + LP_CW'(1)) == w_fill_target);
    assign w_deff_m1     = (i_control1 == 16'd0) ? 16'd0 : (i_control1 - 16'd1);
    // >= rather than == so a decimation factor lowered mid-run wraps at once instead of stalling
    assign w_dec_wrap    = (r_dec_cnt >= w_deff_m1);
    assign w_unused_ctrl = ^i_control0[14:4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_en) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_FLUSH;
                S_FLUSH: begin
                    if (w_len_chg)               w_state_next = S_FLUSH;
                    else if (r_flush_cnt == '0)  w_state_next = S_FILL;
                end
                S_FILL: begin
                    if (w_len_chg)               w_state_next = S_FLUSH;
                    else if (w_fill_done)        w_state_next = S_RUN;
                end
                S_RUN: begin
                    if (w_len_chg)               w_state_next = S_FLUSH;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_len_next = r_len;
        if (w_en && ((r_state == S_IDLE) || w_len_chg)) begin
            w_len_next = w_lreq;
        end

        w_flush_cnt_next = r_flush_cnt;
        if ((w_state_next == S_FLUSH) && ((r_state != S_FLUSH) || w_len_chg)) begin
            w_flush_cnt_next = LP_FLUSH_LOAD;
        end else if ((r_state == S_FLUSH) && (r_flush_cnt != '0)) begin
            w_flush_cnt_next = r_flush_cnt - LP_FW'(1);
        end

        w_fill_cnt_next = '0;
        if (r_state == S_FILL) begin
            w_fill_cnt_next = i_sample_strobe ? (r_fill_cnt + LP_CW'(1)) : r_fill_cnt;
        end

        w_dec_cnt_next      = '0;
        w_output_valid_next = 1'b0;
        if ((r_state == S_RUN) && (w_state_next == S_RUN)) begin
            w_dec_cnt_next = r_dec_cnt;
            if (i_sample_strobe) begin
                w_dec_cnt_next      = w_dec_wrap ? 16'd0 : (r_dec_cnt + 16'd1);
                w_output_valid_next = w_dec_wrap;
            end
        end

        w_avg_clear_next = (w_state_next == S_FLUSH);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush_cnt    <= '0;
            r_fill_cnt     <= '0;
            r_dec_cnt      <= '0;
            r_len          <= '0;
            r_avg_clear    <= 1'b0;
            r_output_valid <= 1'b0;
        end else begin
            r_flush_cnt    <= w_flush_cnt_next;
            r_fill_cnt     <= w_fill_cnt_next;
            r_dec_cnt      <= w_dec_cnt_next;
            r_len          <= w_len_next;
            r_avg_clear    <= w_avg_clear_next;
            r_output_valid <= w_output_valid_next;
        end
    end

    assign o_state          = r_state;
    assign o_avg_clear      = r_avg_clear;
    assign o_output_valid   = r_output_valid;
    assign o_avg_length_log = r_len;
    assign o_busy           = (r_state == S_FLUSH) || (r_state == S_FILL);
    assign o_avg_enable     = !i_rst && i_sample_strobe && ((r_state == S_FILL) || (r_state == S_RUN));

endmodule

// File: tb/tb_avg_window_controller.sv
// Directed bench for avg_window_controller: startup sequence, decimation, relatch,
// enable drop, length clamp and asynchronous reset.
module tb_avg_window_controller;
    logic        clk;
    logic        rst;
    logic [15:0] control0;
    logic [15:0] control1;
    logic        strobe;
    logic        avg_clear;
    logic        avg_enable;
    logic [3:0]  avg_length_log;
    logic        output_valid;
    logic        busy;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    avg_window_controller #(.G_MAX_LENGTH_LOG(10), .G_FLUSH_CYCLES(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_control0       (control0),
        .i_control1       (control1),
        .i_sample_strobe  (strobe),
        .o_avg_clear      (avg_clear),
        .o_avg_enable     (avg_enable),
        .o_avg_length_log (avg_length_log),
        .o_output_valid   (output_valid),
        .o_busy           (busy),
        .o_state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; observation point is just after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Expects to be entered on the first FLUSH cycle with strobe held high.
    task automatic check_startup(input int lg);
        for (int i = 0; i < 4; i++) begin
            chk("flush_state", 32'(state), 32'd1);
            chk("flush_clear", 32'(avg_clear), 32'd1);
            chk("flush_busy", 32'(busy), 32'd1);
            chk("flush_enable", 32'(avg_enable), 32'd0);
            chk("flush_valid", 32'(output_valid), 32'd0);
            chk("flush_len", 32'(avg_length_log), 32'(lg));
            cyc();
        end
        for (int i = 0; i < (1 << lg); i++) begin
            chk("fill_state", 32'(state), 32'd2);
            chk("fill_enable", 32'(avg_enable), 32'd1);
            chk("fill_busy", 32'(busy), 32'd1);
            chk("fill_clear", 32'(avg_clear), 32'd0);
            chk("fill_valid", 32'(output_valid), 32'd0);
            cyc();
        end
        chk("run_entry_state", 32'(state), 32'd3);
        chk("run_entry_busy", 32'(busy), 32'd0);
        chk("run_entry_valid", 32'(output_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        control0 = 16'h0000;
        control1 = 16'd1;
        strobe = 1'b1;
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_clear", 32'(avg_clear), 32'd0);
        chk("rst_valid", 32'(output_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(avg_enable), 32'd0);
        chk("rst_len", 32'(avg_length_log), 32'd0);

        // Basic startup, D=1, strobe every cycle
        rst = 1'b0;
        control0 = 16'h8003;
        cyc();
        check_startup(3);
        for (int i = 0; i < 5; i++) begin
            chk("run_d1_state", 32'(state), 32'd3);
            chk("run_d1_valid", 32'(output_valid), (i > 0) ? 32'd1 : 32'd0);
            cyc();
        end

        // D=3 with strobe on every second cycle: pulse every 6 cycles
        control1 = 16'd3;
        for (int k = 0; k < 24; k++) begin
            strobe = (k % 2 == 0);
            cyc();
            chk("run_d3_valid", 32'(output_valid), (k % 6 == 4) ? 32'd1 : 32'd0);
        end

        // D=0 behaves like D=1
        control1 = 16'd0;
        strobe = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("run_d0_valid", 32'(output_valid), 32'd1);
        end

        // Lowering D below the current count wraps immediately
        control1 = 16'd5;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("run_d5_valid", 32'(output_valid), 32'd0);
        end
        control1 = 16'd2;
        cyc();
        chk("run_lowered_valid", 32'(output_valid), 32'd1);
        control1 = 16'd1;

        // Length change in RUN: refill with the new length, no stray pulse
        control0 = 16'h8002;
        cyc();
        check_startup(2);

        // Length change mid-FLUSH restarts the full clear
        control0 = 16'h8003;
        cyc();
        chk("flush_a_state", 32'(state), 32'd1);
        cyc();
        chk("flush_b_state", 32'(state), 32'd1);
        control0 = 16'h8001;
        cyc();
        check_startup(1);

        // Enable drop in FILL with a simultaneous length change
        control0 = 16'h8003;
        for (int i = 0; i < 5; i++) cyc();
        chk("fill_pre_state", 32'(state), 32'd2);
        cyc();
        control0 = 16'h0005;
        cyc();
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_len", 32'(avg_length_log), 32'd3);
        chk("drop_clear", 32'(avg_clear), 32'd0);
        chk("drop_valid", 32'(output_valid), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_enable", 32'(avg_enable), 32'd0);

        // Requested length above the maximum is clamped to 10
        control0 = 16'h800F;
        cyc();
        check_startup(10);

        // Asynchronous reset between edges while running
        cyc();
        cyc();
        chk("pre_reset_state", 32'(state), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_clear", 32'(avg_clear), 32'd0);
        chk("async_valid", 32'(output_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_enable", 32'(avg_enable), 32'd0);
        chk("async_len", 32'(avg_length_log), 32'd0);
        control0 = 16'h8003;
        #1 rst = 1'b0;
        cyc();
        check_startup(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/avg_window_controller.md
AVG_WINDOW_CONTROLLER -- requirements
Module: avg_window_controller

Interface
REQ-001 Parameter G_MAX_LENGTH_LOG, default 10, is the largest window log2 the downstream moving averager supports.
REQ-002 Parameter G_FLUSH_CYCLES, default 4, is the number of cycles the averager clear is held.
REQ-003 Clk  in  1  single clock; all logic on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Control0  in  16  control word: [15] enable; [3:0] requested window log2; all other bits ignored.
REQ-006 Control1  in  16  output decimation factor D, unsigned.
REQ-007 SampleStrobe  in  1  one-cycle qualifier marking a new input sample.
REQ-008 AvgClear  out  1  synchronous clear to the averager (buffer and accumulator).
REQ-009 AvgEnable  out  1  sample-accept enable to the averager.
REQ-010 AvgLengthLog  out  4  latched window log2 driven to the averager.
REQ-011 OutputValid  out  1  one-cycle pulse marking an averager output to be consumed.
REQ-012 Busy  out  1  high while flushing or filling.
REQ-013 State  out  2  current state encoding: IDLE=00, FLUSH=01, FILL=10, RUN=11.

Function
REQ-014 The state register SHALL implement IDLE, FLUSH, FILL and RUN; all transitions SHALL take effect on a rising Clk edge.
REQ-015 The effective length Lreq SHALL be min(Control0[3:0], G_MAX_LENGTH_LOG).
REQ-016 In IDLE with Control0[15]=1: latch Lreq into AvgLengthLog; go to FLUSH.
REQ-017 In FLUSH: AvgClear=1 for exactly G_FLUSH_CYCLES consecutive cycles; AvgEnable=0; then go to FILL with fill counter = 0.
REQ-018 In FILL: AvgEnable = SampleStrobe, combinationally.
REQ-019 In FILL: the fill counter (G_MAX_LENGTH_LOG+1 bits) increments on each SampleStrobe.
REQ-020 In FILL: State reads RUN on the cycle after the strobe that brings the count to 2^AvgLengthLog.
REQ-021 In FILL: OutputValid=0.
REQ-022 In RUN: AvgEnable = SampleStrobe, combinationally.
REQ-023 In RUN: the decimation counter counts strobes; on the strobe where count >= Deff-1 it wraps to 0 and OutputValid pulses high on the next cycle. Deff = Control1, with 0 treated as 1; read live.
REQ-024 A lowered D mid-run SHALL never stall, by virtue of the >= compare.
REQ-025 The decimation counter SHALL clear on entry to RUN.
REQ-026 In FILL or RUN, Lreq differing from AvgLengthLog SHALL cause a relatch of AvgLengthLog and a return to FLUSH; no OutputValid follows the change.
REQ-027 In FLUSH, an Lreq change SHALL relatch AvgLengthLog and restart the full G_FLUSH_CYCLES clear.
REQ-028 Control0[15]=0 in any state SHALL cause a transition to IDLE on the next edge; AvgEnable, AvgClear and OutputValid are 0 in IDLE.
REQ-029 Enable drop SHALL take priority over a simultaneous length change.
REQ-030 A strobe coincident with a transition out of FILL or RUN SHALL be counted only if the current state is FILL or RUN.
REQ-031 Busy SHALL be 1 in FLUSH and FILL, and 0 otherwise.
REQ-032 OutputValid, AvgClear, AvgLengthLog and State SHALL be registered; AvgEnable is the only combinational output.

Reset
REQ-033 Reset=1 SHALL immediately, without a clock, force State=IDLE, all counters=0, AvgLengthLog=0, AvgClear=0, OutputValid=0 and Busy=0.
REQ-034 While Reset=1, AvgEnable SHALL be 0.
REQ-035 Reset may assert in any state, including mid-FLUSH or mid-FILL; after deassertion the block SHALL restart from IDLE.

Verification
REQ-036 Control0=0x8003, Control1=1, strobe every cycle -> exactly 4 AvgClear cycles, then 8 AvgEnable cycles in FILL with Busy=1, then RUN with one OutputValid per strobe, each one cycle after its strobe.
REQ-037 Control0=0x800F -> AvgLengthLog=10; FILL lasts exactly 1024 strobes.
REQ-038 RUN, Control1=3, strobe every 2nd cycle -> OutputValid period 6 cycles; set Control1=0 mid-run -> pulse after every strobe, no stall.
REQ-039 RUN, Control0 changed 0x8003->0x8002 -> FLUSH for 4 cycles, AvgLengthLog=2, FILL for 4 strobes, no OutputValid until RUN.
REQ-040 FILL, Control0 changed 0x8003->0x0005 in one cycle -> IDLE next edge, AvgLengthLog stays 3, all outputs 0.
REQ-041 Reset pulsed asynchronously mid-RUN, between edges -> all outputs 0 before the next edge; after release with enable=1, a full FLUSH/FILL sequence repeats.
